mpd_controller: RTL and testbench

//  Sequencing FSM for the MPD. Pops one framed packet from the input FIFO and stores it in a free PRT slot.

---
 rtl/mpd_controller.sv | 211 +++++++++++++++++++++
 tb/tb_mpd_controller.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mpd_controller.sv
// MPD sequencing FSM: pops one framed packet into a PRT slot, queries the bloom
// filter, then either streams the stored entry to the output FIFO or drops it.
module mpd_controller #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SLOTS  = 16,
    parameter int MAX_WORDS  = 64,
    parameter int BF_TIMEOUT = 255,
    localparam int SLOT_W    = $clog2(NUM_SLOTS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ip_empty,
    input  logic [DATA_WIDTH-1:0] ip_dout,
    output logic                  ip_rd_en,
    input  logic                  op_full,
    output logic                  op_wr_en,
    output logic [DATA_WIDTH-1:0] op_din,
    input  logic                  is_prt_slot_free,
    input  logic                  RDY_is_prt_slot_free,
    output logic                  EN_start_writing_prt_entry,
    input  logic                  RDY_start_writing_prt_entry,
    input  logic [SLOT_W-1:0]     start_writing_prt_entry,
    output logic                  EN_write_prt_entry,
    input  logic                  RDY_write_prt_entry,
    output logic [DATA_WIDTH-1:0] write_prt_entry_data,
    output logic                  EN_finish_writing_prt_entry,
    input  logic                  RDY_finish_writing_prt_entry,
    output logic                  EN_start_reading_prt_entry,
    input  logic                  RDY_start_reading_prt_entry,
    output logic [SLOT_W-1:0]     start_reading_prt_entry_slot,
    output logic                  EN_read_prt_entry,
    input  logic                  RDY_read_prt_entry,
    input  logic [DATA_WIDTH-1:0] read_prt_entry,
    output logic                  EN_invalidate_prt_entry,
    input  logic                  RDY_invalidate_prt_entry,
    output logic [SLOT_W-1:0]     invalidate_prt_entry_slot,
    output logic                  bf_enable,
    output logic [31:0]           bf_src_ip,
    output logic [31:0]           bf_dest_ip,
    output logic [15:0]           bf_tag,
    input  logic                  bf_busy,
    input  logic                  bf_output_valid,
    input  logic                  bf_safe,
    output logic [31:0]           pkt_fwd_cnt,
    output logic [31:0]           pkt_drop_cnt,
    output logic                  len_err,
    output logic                  bf_timeout,
    output logic                  ctrl_busy
);
    localparam int          TMR_W    = $clog2(BF_TIMEOUT + 1);
    localparam logic [15:0] MAX16    = 16'(MAX_WORDS);
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(BF_TIMEOUT);

    typedef enum logic [3:0] {
        S_IDLE, S_ALLOC, S_WRITE, S_FINISH, S_LOOKUP,
        S_WAIT_BF, S_RD_START, S_RD_DATA, S_INVAL
    } state_t;

    state_t            r_state, w_next;
    logic [SLOT_W-1:0] r_slot;
    logic [15:0]       r_tag;
    logic [31:0]       r_src, r_dst;
    logic [15:0]       r_nwords, r_wcnt, r_stored, r_rcnt;
    logic              r_drop;
    logic [TMR_W-1:0]  r_timer;
    logic [31:0]       r_fwd, r_drp;

    logic        w_pop, w_skip, w_is_hdr, w_len_bad, w_last_wr, w_rd_fire;
    logic [15:0] w_hdr_n, w_n_eff;

    // Words beyond MAX_WORDS are popped and discarded without touching the PRT.
    assign w_skip    = (r_wcnt >= MAX16);
    assign w_pop     = (r_state == S_WRITE) && !ip_empty && (w_skip || RDY_write_prt_entry);
    assign w_is_hdr  = (r_wcnt == 16'd0);
    assign w_hdr_n   = ip_dout[31:16];
    assign w_len_bad = (w_hdr_n < 16'd3) || (w_hdr_n > MAX16);
    assign w_n_eff   = w_is_hdr ? ((w_hdr_n < 16'd3) ? 16'd3 : w_hdr_n) : r_nwords;
    assign w_last_wr = (r_wcnt == w_n_eff - 16'd1);
    assign w_rd_fire = (r_state == S_RD_DATA) && RDY_read_prt_entry && !op_full;

    always_comb begin
        w_next                      = r_state;
        ip_rd_en                    = 1'b0;
        op_wr_en                    = 1'b0;
        EN_start_writing_prt_entry  = 1'b0;
        EN_write_prt_entry          = 1'b0;
        EN_finish_writing_prt_entry = 1'b0;
        EN_start_reading_prt_entry  = 1'b0;
        EN_read_prt_entry           = 1'b0;
        EN_invalidate_prt_entry     = 1'b0;
        bf_enable                   = 1'b0;
        len_err                     = 1'b0;
        bf_timeout                  = 1'b0;
        case (r_state)
            S_IDLE:
                if (!ip_empty && is_prt_slot_free && RDY_is_prt_slot_free) w_next = S_ALLOC;
            S_ALLOC:
                if (RDY_start_writing_prt_entry) begin
                    EN_start_writing_prt_entry = 1'b1;
                    w_next = S_WRITE;
                end
            S_WRITE:
                if (w_pop) begin
                    ip_rd_en           = 1'b1;
                    EN_write_prt_entry = !w_skip;
                    len_err            = w_is_hdr && w_len_bad;
                    if (w_last_wr) w_next = S_FINISH;
                end
            S_FINISH:
                if (RDY_finish_writing_prt_entry) begin
                    EN_finish_writing_prt_entry = 1'b1;
                    w_next = r_drop ? S_INVAL : S_LOOKUP;
                end
            S_LOOKUP:
                if (!bf_busy) begin
                    bf_enable = 1'b1;
                    w_next    = S_WAIT_BF;
                end
            S_WAIT_BF:
                if (bf_output_valid) begin
                    w_next = bf_safe ? S_RD_START : S_INVAL;
                end else if (r_timer == TMR_MAX) begin
                    bf_timeout = 1'b1;
                    w_next     = S_INVAL;
                end
            S_RD_START:
                if (RDY_start_reading_prt_entry) begin
                    EN_start_reading_prt_entry = 1'b1;
                    w_next = S_RD_DATA;
                end
            S_RD_DATA:
                if (w_rd_fire) begin
                    EN_read_prt_entry = 1'b1;
                    op_wr_en          = 1'b1;
                    if (r_rcnt == r_stored - 16'd1) w_next = S_INVAL;
                end
            S_INVAL:
                if (RDY_invalidate_prt_entry) begin
                    EN_invalidate_prt_entry = 1'b1;
                    w_next = S_IDLE;
                end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_slot   <= '0;
            r_tag    <= '0;
            r_src    <= '0;
            r_dst    <= '0;
            r_nwords <= '0;
            r_wcnt   <= '0;
            r_stored <= '0;
            r_rcnt   <= '0;
            r_drop   <= 1'b0;
            r_timer  <= '0;
            r_fwd    <= '0;
            r_drp    <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    r_wcnt <= '0;
                    r_drop <= 1'b0;
                end
                S_ALLOC:
                    if (RDY_start_writing_prt_entry) r_slot <= start_writing_prt_entry;
                S_WRITE:
                    if (w_pop) begin
                        r_wcnt <= r_wcnt + 16'd1;
                        if (w_is_hdr) begin
                            r_tag    <= ip_dout[15:0];
                            r_nwords <= w_n_eff;
                            r_stored <= (w_n_eff > MAX16) ? MAX16 : w_n_eff;
                            r_drop   <= w_len_bad;
                        end
                        if (r_wcnt == 16'd1) r_src <= ip_dout[31:0];
                        if (r_wcnt == 16'd2) r_dst <= ip_dout[31:0];
                    end
                S_LOOKUP: r_timer <= '0;
                S_WAIT_BF: begin
                    r_timer <= r_timer + 1'b1;
                    if ((bf_output_valid && !bf_safe) ||
                        (!bf_output_valid && r_timer == TMR_MAX)) r_drop <= 1'b1;
                end
                S_RD_START: r_rcnt <= '0;
                S_RD_DATA:
                    if (w_rd_fire) r_rcnt <= r_rcnt + 16'd1;
                S_INVAL:
                    if (RDY_invalidate_prt_entry) begin
                        if (r_drop) r_drp <= r_drp + 32'd1;
                        else        r_fwd <= r_fwd + 32'd1;
                    end
                default: ;
            endcase
        end
    end

    assign write_prt_entry_data         = EN_write_prt_entry ? ip_dout : '0;
    assign op_din                       = op_wr_en ? read_prt_entry : '0;
    assign start_reading_prt_entry_slot = r_slot;
    assign invalidate_prt_entry_slot    = r_slot;
    assign bf_src_ip                    = r_src;
    assign bf_dest_ip                   = r_dst;
    assign bf_tag                       = r_tag;
    assign pkt_fwd_cnt                  = r_fwd;
    assign pkt_drop_cnt                 = r_drp;
    assign ctrl_busy                    = (r_state != S_IDLE);
endmodule

// File: tb/tb_mpd_controller.sv
// Directed bench for mpd_controller with small FIFO, PRT and bloom-filter models.
module tb_mpd_controller;
    localparam int DW = 32, NS = 16, SW = 4, MW = 64, BT = 255;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          ip_empty, ip_rd_en, op_full, op_wr_en;
    logic [DW-1:0] ip_dout, op_din;
    logic          is_prt_slot_free, RDY_is_prt_slot_free;
    logic          EN_start_writing_prt_entry, RDY_start_writing_prt_entry;
    logic [SW-1:0] start_writing_prt_entry;
    logic          EN_write_prt_entry, RDY_write_prt_entry;
    logic [DW-1:0] write_prt_entry_data;
    logic          EN_finish_writing_prt_entry, RDY_finish_writing_prt_entry;
    logic          EN_start_reading_prt_entry, RDY_start_reading_prt_entry;
    logic [SW-1:0] start_reading_prt_entry_slot;
    logic          EN_read_prt_entry, RDY_read_prt_entry;
    logic [DW-1:0] read_prt_entry;
    logic          EN_invalidate_prt_entry, RDY_invalidate_prt_entry;
    logic [SW-1:0] invalidate_prt_entry_slot;
    logic          bf_enable, bf_busy, bf_output_valid, bf_safe;
    logic [31:0]   bf_src_ip, bf_dest_ip, pkt_fwd_cnt, pkt_drop_cnt;
    logic [15:0]   bf_tag;
    logic          len_err, bf_timeout, ctrl_busy;

    mpd_controller #(.DATA_WIDTH(DW), .NUM_SLOTS(NS), .MAX_WORDS(MW), .BF_TIMEOUT(BT)) dut (
        .clk(clk), .rst_n(rst_n),
        .ip_empty(ip_empty), .ip_dout(ip_dout), .ip_rd_en(ip_rd_en),
        .op_full(op_full), .op_wr_en(op_wr_en), .op_din(op_din),
        .is_prt_slot_free(is_prt_slot_free), .RDY_is_prt_slot_free(RDY_is_prt_slot_free),
        .EN_start_writing_prt_entry(EN_start_writing_prt_entry),
        .RDY_start_writing_prt_entry(RDY_start_writing_prt_entry),
        .start_writing_prt_entry(start_writing_prt_entry),
        .EN_write_prt_entry(EN_write_prt_entry), .RDY_write_prt_entry(RDY_write_prt_entry),
        .write_prt_entry_data(write_prt_entry_data),
        .EN_finish_writing_prt_entry(EN_finish_writing_prt_entry),
        .RDY_finish_writing_prt_entry(RDY_finish_writing_prt_entry),
        .EN_start_reading_prt_entry(EN_start_reading_prt_entry),
        .RDY_start_reading_prt_entry(RDY_start_reading_prt_entry),
        .start_reading_prt_entry_slot(start_reading_prt_entry_slot),
        .EN_read_prt_entry(EN_read_prt_entry), .RDY_read_prt_entry(RDY_read_prt_entry),
        .read_prt_entry(read_prt_entry),
        .EN_invalidate_prt_entry(EN_invalidate_prt_entry),
        .RDY_invalidate_prt_entry(RDY_invalidate_prt_entry),
        .invalidate_prt_entry_slot(invalidate_prt_entry_slot),
        .bf_enable(bf_enable), .bf_src_ip(bf_src_ip), .bf_dest_ip(bf_dest_ip), .bf_tag(bf_tag),
        .bf_busy(bf_busy), .bf_output_valid(bf_output_valid), .bf_safe(bf_safe),
        .pkt_fwd_cnt(pkt_fwd_cnt), .pkt_drop_cnt(pkt_drop_cnt),
        .len_err(len_err), .bf_timeout(bf_timeout), .ctrl_busy(ctrl_busy)
    );

    // Environment models
    logic [31:0] in_mem  [0:511];
    logic [31:0] out_mem [0:511];
    logic [31:0] prt_mem [0:1023];
    int in_wr, in_rd, out_cnt, wp, rp, bf_cd, bf_mode, cyc, t_en, t_to;
    logic gap;
    logic [SW-1:0] wslot, rslot, inv_slot;
    logic [31:0] cap_src, cap_dst;
    logic [15:0] cap_tag;
    int n_pop, n_startw, n_write, n_bfen, n_rds, n_inval, n_len, n_tmo;
    int en_viol, multi_viol, full_viol, gap_viol;

    assign ip_dout         = in_mem[in_rd[8:0]];
    assign ip_empty        = gap || (in_rd == in_wr);
    assign read_prt_entry  = prt_mem[{rslot, rp[5:0]}];
    assign bf_output_valid = (bf_cd == 1) && (bf_mode != 2);
    assign bf_safe         = (bf_mode == 0);

    initial begin
        cyc = 0; in_rd = 0; out_cnt = 0; wp = 0; rp = 0; bf_cd = 0;
        n_pop = 0; n_startw = 0; n_write = 0; n_bfen = 0; n_rds = 0; n_inval = 0;
        n_len = 0; n_tmo = 0; en_viol = 0; multi_viol = 0; full_viol = 0; gap_viol = 0;
        t_en = 0; t_to = 0; wslot = '0; rslot = '0; inv_slot = '0;
        cap_src = '0; cap_dst = '0; cap_tag = '0;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) begin
            in_rd <= 0;
            bf_cd <= 0;
        end else begin
            if (ip_rd_en) begin in_rd <= in_rd + 1; n_pop <= n_pop + 1; end
            if (EN_start_writing_prt_entry) begin
                wslot <= start_writing_prt_entry; wp <= 0; n_startw <= n_startw + 1;
            end
            if (EN_write_prt_entry) begin
                prt_mem[{wslot, wp[5:0]}] <= write_prt_entry_data; wp <= wp + 1; n_write <= n_write + 1;
            end
            if (EN_start_reading_prt_entry) begin
                rslot <= start_reading_prt_entry_slot; rp <= 0; n_rds <= n_rds + 1;
            end
            if (EN_read_prt_entry) rp <= rp + 1;
            if (op_wr_en) begin out_mem[out_cnt[8:0]] <= op_din; out_cnt <= out_cnt + 1; end
            if (EN_invalidate_prt_entry) begin inv_slot <= invalidate_prt_entry_slot; n_inval <= n_inval + 1; end
            if (bf_enable) begin
                bf_cd <= 3; t_en <= cyc; n_bfen <= n_bfen + 1;
                cap_src <= bf_src_ip; cap_dst <= bf_dest_ip; cap_tag <= bf_tag;
            end else if (bf_cd > 0) bf_cd <= bf_cd - 1;
            if (len_err) n_len <= n_len + 1;
            if (bf_timeout) begin t_to <= cyc; n_tmo <= n_tmo + 1; end
            if ((EN_start_writing_prt_entry && !RDY_start_writing_prt_entry) ||
                (EN_write_prt_entry && !RDY_write_prt_entry) ||
                (EN_finish_writing_prt_entry && !RDY_finish_writing_prt_entry) ||
                (EN_start_reading_prt_entry && !RDY_start_reading_prt_entry) ||
                (EN_read_prt_entry && !RDY_read_prt_entry) ||
                (EN_invalidate_prt_entry && !RDY_invalidate_prt_entry)) en_viol <= en_viol + 1;
            if ($countones({EN_start_writing_prt_entry, EN_write_prt_entry, EN_finish_writing_prt_entry,
                            EN_start_reading_prt_entry, EN_read_prt_entry, EN_invalidate_prt_entry}) > 1)
                multi_viol <= multi_viol + 1;
            if (op_full && (op_wr_en || EN_read_prt_entry)) full_viol <= full_viol + 1;
            if (gap && ip_rd_en) gap_viol <= gap_viol + 1;
        end
    end

    int errors = 0, checks = 0;
    int s_pop, s_write, s_bfen, s_rds, s_inval, s_len, s_tmo, s_out, pkt_base;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        s_pop = n_pop; s_write = n_write; s_bfen = n_bfen; s_rds = n_rds;
        s_inval = n_inval; s_len = n_len; s_tmo = n_tmo; s_out = out_cnt;
    endtask

    // hdr_n goes into w0[31:16]; nw words are actually placed in the FIFO.
    task automatic push_pkt(input logic [15:0] hdr_n, input int nw, input logic [15:0] tag,
                            input logic [31:0] src, input logic [31:0] dst);
        pkt_base = in_wr;
        for (int i = 0; i < nw; i++) begin
            if (i == 0)      in_mem[in_wr + i] = {hdr_n, tag};
            else if (i == 1) in_mem[in_wr + i] = src;
            else if (i == 2) in_mem[in_wr + i] = dst;
            else             in_mem[in_wr + i] = 32'hC0DE_0000 + 32'(in_wr + i);
        end
        in_wr = in_wr + nw;
    endtask

    task automatic wait_total(input int tot);
        for (int i = 0; i < 3000; i++) begin
            if ((pkt_fwd_cnt + pkt_drop_cnt == 32'(tot)) && !ctrl_busy) break;
            @(negedge clk);
        end
        chk("pkt_done", pkt_fwd_cnt + pkt_drop_cnt, tot);
    endtask

    task automatic chk_out(input string tag, input int n);
        chk({tag, "_outcnt"}, out_cnt - s_out, n);
        for (int i = 0; i < n; i++)
            chk({tag, "_word"}, out_mem[s_out + i], in_mem[pkt_base + i]);
    endtask

    initial begin
        rst_n = 1'b0; in_wr = 0; gap = 1'b0; op_full = 1'b0; bf_busy = 1'b0; bf_mode = 0;
        is_prt_slot_free = 1'b1; RDY_is_prt_slot_free = 1'b1;
        RDY_start_writing_prt_entry = 1'b1; RDY_write_prt_entry = 1'b1;
        RDY_finish_writing_prt_entry = 1'b1; RDY_start_reading_prt_entry = 1'b1;
        RDY_read_prt_entry = 1'b1; RDY_invalidate_prt_entry = 1'b1;
        start_writing_prt_entry = 4'd5;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_busy", ctrl_busy, 0);
        chk("rst_fwd", pkt_fwd_cnt, 0);
        chk("rst_drop", pkt_drop_cnt, 0);
        chk("rst_ctl", {ip_rd_en, op_wr_en, bf_enable, len_err, bf_timeout}, 0);
        chk("rst_data", {op_din, write_prt_entry_data, bf_src_ip, bf_dest_ip, bf_tag}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: safe packet N=5, start_writing held off for a few cycles first
        snap();
        RDY_start_writing_prt_entry = 1'b0;
        push_pkt(16'd5, 5, 16'h00AB, 32'h0A00_0001, 32'h0A00_0002);
        repeat (4) @(negedge clk);
        chk("t1_alloc_busy", ctrl_busy, 1);
        chk("t1_alloc_stall", n_startw - s_pop, 0);
        RDY_start_writing_prt_entry = 1'b1;
        wait_total(1);
        chk("t1_writes", n_write - s_write, 5);
        chk("t1_bfen", n_bfen - s_bfen, 1);
        chk("t1_src", cap_src, 32'h0A00_0001);
        chk("t1_dst", cap_dst, 32'h0A00_0002);
        chk("t1_tag", cap_tag, 16'h00AB);
        chk_out("t1", 5);
        chk("t1_inval", n_inval - s_inval, 1);
        chk("t1_inval_slot", inv_slot, 4'd5);
        chk("t1_fwd", pkt_fwd_cnt, 1);
        chk("t1_drop", pkt_drop_cnt, 0);

        // 2: unsafe packet N=4
        snap(); bf_mode = 1; start_writing_prt_entry = 4'd3;
        push_pkt(16'd4, 4, 16'h1234, 32'hC0A8_0001, 32'hC0A8_0002);
        wait_total(2);
        chk("t2_rdstart", n_rds - s_rds, 0);
        chk("t2_opwr", out_cnt - s_out, 0);
        chk("t2_inval", n_inval - s_inval, 1);
        chk("t2_inval_slot", inv_slot, 4'd3);
        chk("t2_drop", pkt_drop_cnt, 1);
        chk("t2_fwd", pkt_fwd_cnt, 1);

        // 3: bloom filter never answers
        snap(); bf_mode = 2; start_writing_prt_entry = 4'd9;
        push_pkt(16'd3, 3, 16'h0042, 32'h1111_0000, 32'h2222_0000);
        wait_total(3);
        chk("t3_tmo_pulses", n_tmo - s_tmo, 1);
        chk("t3_tmo_latency", t_to - t_en, BT + 1);
        chk("t3_inval_slot", inv_slot, 4'd9);
        chk("t3_drop", pkt_drop_cnt, 2);
        chk("t3_opwr", out_cnt - s_out, 0);

        // 4: oversize N=70, then a minimum-length packet forwarded intact
        snap(); bf_mode = 0; start_writing_prt_entry = 4'd1;
        push_pkt(16'd70, 70, 16'h0070, 32'h0303_0303, 32'h0404_0404);
        wait_total(4);
        chk("t4_writes", n_write - s_write, 64);
        chk("t4_pops", n_pop - s_pop, 70);
        chk("t4_lenerr", n_len - s_len, 1);
        chk("t4_drop", pkt_drop_cnt, 3);
        chk("t4_opwr", out_cnt - s_out, 0);
        snap();
        push_pkt(16'd3, 3, 16'h0003, 32'h0505_0505, 32'h0606_0606);
        wait_total(5);
        chk_out("t4b", 3);
        chk("t4b_fwd", pkt_fwd_cnt, 2);
        chk("t4b_lenerr", n_len - s_len, 0);

        // 4c: undersize header N=1 is consumed as 3 words and dropped
        snap();
        push_pkt(16'd1, 3, 16'h0001, 32'h0707_0707, 32'h0808_0808);
        wait_total(6);
        chk("t4c_pops", n_pop - s_pop, 3);
        chk("t4c_writes", n_write - s_write, 3);
        chk("t4c_lenerr", n_len - s_len, 1);
        chk("t4c_drop", pkt_drop_cnt, 4);
        chk("t4c_bfen", n_bfen - s_bfen, 0);

        // 5: input gaps during WRITE and op_full during RD_DATA
        snap(); start_writing_prt_entry = 4'd12;
        push_pkt(16'd8, 8, 16'h0BEE, 32'hAAAA_0001, 32'hBBBB_0002);
        for (int i = 0; i < 200 && (n_write - s_write < 2); i++) @(negedge clk);
        gap = 1'b1;
        repeat (4) @(negedge clk);
        gap = 1'b0;
        for (int i = 0; i < 400 && (out_cnt - s_out < 3); i++) @(negedge clk);
        op_full = 1'b1;
        repeat (10) @(negedge clk);
        op_full = 1'b0;
        wait_total(7);
        chk_out("t5", 8);
        chk("t5_full_viol", full_viol, 0);
        chk("t5_gap_viol", gap_viol, 0);
        chk("t5_fwd", pkt_fwd_cnt, 3);
        chk("en_rdy_viol", en_viol, 0);
        chk("multi_en_viol", multi_viol, 0);

        // 6: reset while waiting on the bloom filter
        snap(); bf_mode = 2;
        push_pkt(16'd3, 3, 16'h0066, 32'h0909_0909, 32'h0A0A_0A0A);
        for (int i = 0; i < 200 && (n_bfen == s_bfen); i++) @(negedge clk);
        chk("t6_reached_bf", n_bfen - s_bfen, 1);
        repeat (5) @(negedge clk);
        rst_n = 1'b0; in_wr = 0;
        @(negedge clk);
        chk("t6_en", {EN_start_writing_prt_entry, EN_write_prt_entry, EN_finish_writing_prt_entry,
                      EN_start_reading_prt_entry, EN_read_prt_entry, EN_invalidate_prt_entry,
                      bf_enable, ip_rd_en, op_wr_en}, 0);
        chk("t6_busy", ctrl_busy, 0);
        chk("t6_cnts", {pkt_fwd_cnt, pkt_drop_cnt}, 0);
        chk("t6_no_inval", n_inval - s_inval, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("t6_idle_after", ctrl_busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
